// File: rtl/mrd_mem_pkt.sv
`default_nettype none
// ============================================================================
// Module      : mrd_mem_pkt (package)
// Description : Shared widths, feeder FSM encoding and packet-length check
//               for the mixed-radix DFT memory sink feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package mrd_mem_pkt;

    localparam int c_wADDR   = 11;
    localparam int c_wD      = 18;
    localparam int c_DPTS_W  = 12;
    localparam int c_SIZE_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_WAIT_RDY = 2'd2,
        ST_SEND     = 2'd3
    } feeder_state_t;

    // Legal packets hold 2..2^waddr samples; single-sample packets are rejected.
    function automatic logic len_legal(input logic [c_DPTS_W-1:0] dpts, input int waddr);
        return (32'(dpts) >= 32'd2) && (32'(dpts) <= (32'd1 << waddr));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mrd_feeder_buf.sv
`default_nettype none
// ============================================================================
// Module      : mrd_feeder_buf
// Description : Simple dual-port sample buffer, one write and one registered
//               read port (1-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module mrd_feeder_buf
    import mrd_mem_pkt::*;
#(
    parameter int wADDR = c_wADDR,
    parameter int wDATA = 2 * c_wD
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [wADDR-1:0] wr_addr,
    input  logic [wDATA-1:0] wr_data,
    input  logic             rd_en,
    input  logic [wADDR-1:0] rd_addr,
    output logic [wDATA-1:0] rd_data
);

    logic [wDATA-1:0] r_mem [0:(1<<wADDR)-1];
    logic [wDATA-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/mrd_sink_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mrd_sink_feeder
// Description : Buffers one upstream DFT packet, then replays it as a single
//               gap-free sop/valid/eop burst once the memory top is idle.
// Revision    : 1.0 - initial release
// ============================================================================
module mrd_sink_feeder
    import mrd_mem_pkt::*;
#(
    parameter int wADDR = c_wADDR,
    parameter int wD    = c_wD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic                up_sop,
    input  logic                up_eop,
    input  logic [wD-1:0]       up_real,
    input  logic [wD-1:0]       up_imag,
    input  logic [c_DPTS_W-1:0] up_dftpts,
    input  logic [c_SIZE_W-1:0] up_size,
    input  logic                sink_ready,
    output logic                tx_valid,
    output logic                tx_sop,
    output logic                tx_eop,
    output logic [wD-1:0]       tx_real,
    output logic [wD-1:0]       tx_imag,
    output logic [c_DPTS_W-1:0] tx_dftpts,
    output logic [c_SIZE_W-1:0] tx_size,
    output logic                err,
    output logic                busy
);

    localparam int c_CW = wADDR + 1;

    feeder_state_t       r_state;
    feeder_state_t       w_state_next;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_next;
    logic [c_CW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     w_rd_ptr_next;
    logic [c_CW-1:0]     w_rd_addr;
    logic [c_DPTS_W-1:0] r_dftpts;
    logic [c_SIZE_W-1:0] r_size;
    logic                w_accept;
    logic                w_len_ok;
    logic                w_last_beat;
    logic                w_load;
    logic                w_wr_en;
    logic [wADDR-1:0]    w_wr_addr;
    logic                w_rd_en;
    logic                w_err;
    logic [2*wD-1:0]     w_rd_data;
    logic                r_p1_valid;
    logic                r_p1_sop;
    logic                r_p1_eop;
    logic                r_tx_valid;
    logic                r_tx_sop;
    logic                r_tx_eop;
    logic [wD-1:0]       r_tx_real;
    logic [wD-1:0]       r_tx_imag;
    logic [c_DPTS_W-1:0] r_tx_dftpts;
    logic [c_SIZE_W-1:0] r_tx_size;
    logic                r_err;

    assign up_ready    = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign busy        = (r_state != ST_IDLE);
    assign w_accept    = up_valid && up_ready;
    assign w_len_ok    = len_legal(up_dftpts, wADDR);
    assign w_last_beat = (32'(r_cnt) == (32'(r_dftpts) - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_rd_ptr_next = r_rd_ptr;
        w_rd_addr     = r_rd_ptr;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_cnt[wADDR-1:0];
        w_load        = 1'b0;
        w_rd_en       = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next    = '0;
                w_rd_ptr_next = '0;
                if (w_accept) begin
                    if (up_sop && w_len_ok) begin
                        w_wr_en      = 1'b1;
                        w_wr_addr    = '0;
                        w_load       = 1'b1;
                        w_cnt_next   = c_CW'(1);
                        w_state_next = ST_FILL;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    if (up_sop) begin
                        // A fresh sop abandons the partial packet and restarts on this beat.
                        w_err = 1'b1;
                        if (w_len_ok) begin
                            w_wr_en    = 1'b1;
                            w_wr_addr  = '0;
                            w_load     = 1'b1;
                            w_cnt_next = c_CW'(1);
                        end else begin
                            w_cnt_next   = '0;
                            w_state_next = ST_IDLE;
                        end
                    end else if (w_last_beat) begin
                        w_wr_en      = 1'b1;
                        w_err        = !up_eop;
                        w_state_next = ST_WAIT_RDY;
                    end else if (up_eop) begin
                        w_err        = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (sink_ready) begin
                    w_rd_en       = 1'b1;
                    w_rd_addr     = '0;
                    w_rd_ptr_next = c_CW'(1);
                    w_state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                // sink_ready is not consulted here: the sink cannot stall mid-burst.
                if (32'(r_rd_ptr) < 32'(r_dftpts)) begin
                    w_rd_en       = 1'b1;
                    w_rd_ptr_next = r_rd_ptr + 1'b1;
                end
                if (r_tx_eop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_dftpts <= '0;
            r_size   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_err    <= w_err;
            if (w_load) begin
                r_dftpts <= up_dftpts;
                r_size   <= up_size;
            end
        end
    end

    mrd_feeder_buf #(
        .wADDR (wADDR),
        .wDATA (2 * wD)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data ({up_real, up_imag}),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr[wADDR-1:0]),
        .rd_data (w_rd_data)
    );

    // Framing flags travel alongside the RAM read so they line up with its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_sop   <= 1'b0;
            r_p1_eop   <= 1'b0;
        end else begin
            r_p1_valid <= w_rd_en;
            r_p1_sop   <= w_rd_en && (w_rd_addr == '0);
            r_p1_eop   <= w_rd_en && (32'(w_rd_addr) == (32'(r_dftpts) - 32'd1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid  <= 1'b0;
            r_tx_sop    <= 1'b0;
            r_tx_eop    <= 1'b0;
            r_tx_real   <= '0;
            r_tx_imag   <= '0;
            r_tx_dftpts <= '0;
            r_tx_size   <= '0;
        end else begin
            r_tx_valid  <= r_p1_valid;
            r_tx_sop    <= r_p1_sop;
            r_tx_eop    <= r_p1_eop;
            r_tx_real   <= r_p1_valid ? w_rd_data[2*wD-1:wD] : '0;
            r_tx_imag   <= r_p1_valid ? w_rd_data[wD-1:0]    : '0;
            r_tx_dftpts <= r_p1_valid ? r_dftpts : '0;
            r_tx_size   <= r_p1_valid ? r_size   : '0;
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_sop    = r_tx_sop;
    assign tx_eop    = r_tx_eop;
    assign tx_real   = r_tx_real;
    assign tx_imag   = r_tx_imag;
    assign tx_dftpts = r_tx_dftpts;
    assign tx_size   = r_tx_size;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mrd_sink_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mrd_sink_feeder
// Description : Scoreboard bench for mrd_sink_feeder framing, timing and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mrd_sink_feeder;

    typedef struct {
        logic [17:0] re;
        logic [17:0] im;
        logic        sop;
        logic        eop;
        logic [11:0] dp;
        logic [5:0]  sz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic        up_sop = 1'b0;
    logic        up_eop = 1'b0;
    logic [17:0] up_real = '0;
    logic [17:0] up_imag = '0;
    logic [11:0] up_dftpts = '0;
    logic [5:0]  up_size = '0;
    logic        sink_ready = 1'b1;
    logic        tx_valid, tx_sop, tx_eop, err, busy;
    logic [17:0] tx_real, tx_imag;
    logic [11:0] tx_dftpts;
    logic [5:0]  tx_size;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   err_seen = 0;
    int   rx_count = 0;
    int   sop_cyc = -1;
    int   eop_cyc = -1;
    int   fall_cyc = -1;
    int   last_acc_cyc = 0;
    exp_t q[$];

    mrd_sink_feeder #(.wADDR(11), .wD(18)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_sop(up_sop), .up_eop(up_eop),
        .up_real(up_real), .up_imag(up_imag), .up_dftpts(up_dftpts), .up_size(up_size),
        .sink_ready(sink_ready),
        .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_real(tx_real), .tx_imag(tx_imag), .tx_dftpts(tx_dftpts), .tx_size(tx_size),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] f_re(input int seed, input int i);
        return 18'(seed * 1000 + i);
    endfunction

    function automatic logic [17:0] f_im(input int seed, input int i);
        return 18'(seed * 31 + i * 5 + 'h1ABCD);
    endfunction

    task automatic beat(input logic s, input logic e, input logic [17:0] re, input logic [17:0] im,
                        input logic [11:0] dp, input logic [5:0] sz);
        int g = 0;
        up_sop = s; up_eop = e; up_real = re; up_imag = im;
        up_dftpts = dp; up_size = sz; up_valid = 1'b1;
        while (!up_ready && g < 10000) begin
            @(posedge clk); #1; g++;
        end
        if (!up_ready) begin
            n_chk++; n_err++;
            $display("FAIL beat_timeout: up_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        last_acc_cyc = cyc;
        up_valid = 1'b0; up_sop = 1'b0; up_eop = 1'b0;
    endtask

    task automatic drive_pkt(input int nb, input int dp, input int sz, input int seed, input int eop_idx);
        for (int i = 0; i < nb; i++)
            beat(i == 0, i == eop_idx, f_re(seed, i), f_im(seed, i), 12'(dp), 6'(sz));
    endtask

    task automatic expect_pkt(input int n, input int sz, input int seed);
        for (int i = 0; i < n; i++)
            q.push_back('{re: f_re(seed, i), im: f_im(seed, i), sop: (i == 0),
                          eop: (i == n - 1), dp: 12'(n), sz: 6'(sz)});
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        do begin
            @(posedge clk); #1; g++;
        end while ((q.size() != 0 || busy) && g < 20000);
        chk(nm, {31'(q.size()), busy}, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every tx beat and watches burst contiguity.
    initial begin
        logic pv = 1'b0, pe = 1'b0, pb = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pe = 1'b0; pb = 1'b0;
            end else begin
                if (err) err_seen++;
                if (pv && !pe) chk("tx_gap", tx_valid, 1);
                if (tx_valid) begin
                    if (q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL tx_unexpected: got valid sample %0h, required none", tx_real);
                    end else begin
                        e = q.pop_front();
                        chk("tx_sample", {tx_real, tx_imag, tx_sop, tx_eop, tx_dftpts, tx_size},
                            {e.re, e.im, e.sop, e.eop, e.dp, e.sz});
                    end
                    rx_count++;
                    if (tx_sop) sop_cyc = cyc;
                    if (tx_eop) eop_cyc = cyc;
                end
                if (pb && !busy) begin
                    fall_cyc = cyc;
                    chk("up_ready_at_idle", up_ready, 1);
                end
                pv = tx_valid; pe = tx_eop; pb = busy;
            end
        end
    end

    initial begin
        int t;
        int viol;
        int base;
        int g;

        #2;
        chk("reset_tx", {tx_valid, tx_sop, tx_eop, tx_real, tx_imag, tx_dftpts, tx_size}, 0);
        chk("reset_err_busy", {err, busy}, 0);
        chk("reset_up_ready", up_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Nominal 12-point packet
        expect_pkt(12, 3, 1);
        drive_pkt(12, 12, 3, 1, 11);
        t = last_acc_cyc;
        wait_idle("nominal_drain");
        chk("nominal_sop_time", sop_cyc - t, 2);
        chk("nominal_eop_time", eop_cyc - t, 13);
        chk("nominal_busy_fall", fall_cyc - t, 14);
        chk("nominal_err", err_seen, 0);

        // Backpressure: 1200 samples held off by sink_ready for 500 cycles
        sink_ready = 1'b0;
        expect_pkt(1200, 10, 2);
        drive_pkt(1200, 1200, 10, 2, 1199);
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (up_ready || tx_valid || !busy) viol++;
        end
        chk("wait_rdy_hold", viol, 0);
        sink_ready = 1'b1;
        t = cyc;
        wait_idle("bp_drain");
        chk("bp_sop_time", sop_cyc - t, 2);
        chk("bp_eop_time", eop_cyc - t, 1201);
        chk("bp_busy_fall", fall_cyc - eop_cyc, 1);

        // Early eop on beat 10 of a 24-point packet, then a good 36-point packet
        drive_pkt(10, 24, 4, 3, 9);
        wait_idle("early_eop_idle");
        chk("early_eop_err", err_seen, 1);
        expect_pkt(36, 5, 4);
        drive_pkt(36, 36, 5, 4, 35);
        wait_idle("n36_drain");
        chk("n36_err", err_seen, 1);

        // Mid-packet sop at beat 20 of a 48-point packet
        drive_pkt(20, 48, 6, 5, -1);
        expect_pkt(48, 6, 6);
        drive_pkt(48, 48, 6, 6, 47);
        wait_idle("mid_sop_drain");
        chk("mid_sop_err", err_seen, 2);

        // Illegal lengths
        beat(1'b1, 1'b0, 18'h1, 18'h2, 12'd0, 6'd1);
        beat(1'b1, 1'b0, 18'h3, 18'h4, 12'd2049, 6'd1);
        wait_idle("illegal_idle");
        chk("illegal_err", err_seen, 4);
        chk("illegal_up_ready", up_ready, 1);

        // Asynchronous reset at sample 100 of a 300-point burst
        base = rx_count;
        expect_pkt(300, 7, 7);
        drive_pkt(300, 300, 7, 7, 299);
        g = 0;
        while (rx_count < base + 100 && g < 5000) begin
            @(posedge clk); g++;
        end
        #3 rst = 1'b1;
        #1;
        chk("rst_at_sample", rx_count - base, 100);
        chk("rst_tx_zero", {tx_valid, tx_sop, tx_eop, tx_real, tx_imag, tx_dftpts, tx_size}, 0);
        chk("rst_busy_err", {busy, err}, 0);
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        expect_pkt(60, 8, 9);
        drive_pkt(60, 60, 8, 9, 59);
        t = last_acc_cyc;
        wait_idle("post_rst_drain");
        chk("post_rst_sop_time", sop_cyc - t, 2);
        chk("final_err", err_seen, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
